// File: rtl/zuc_fsm.sv
// ---------------------------------------------------------------------------
// zuc_fsm -- ZUC nonlinear function F (memory cells R1/R2, W generation).
//
// Sits directly downstream of the bit-reorganisation/LFSR stage. For every
// accepted word triple (x0, x1, x2) it emits W = (X0 ^ R1) + R2 one cycle
// later, and advances R1/R2 through the L1/L2 linear maps and the ZUC S-box
// layer (S0/S1/S0/S1 per 32-bit word, two words -> 8 S-box instances).
//
// Optional feature, macro ZUC_FSM_PIPE_EN:
//   undefined : single-cycle R1/R2 update, in_rdy tied 1 (1 triple/cycle).
//   defined   : L1/L2 results registered before the S-boxes; IDLE/UPD FSM,
//               in_rdy low during UPD (1 triple per 2 cycles). W timing and
//               W values are identical to the default build.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   clr      in   1  synchronous clear of R1/R2 to RST_R1/RST_R2, drops triple
//   in_vld   in   1  x0/x1/x2 valid
//   in_rdy   out  1  block can accept this cycle
//   x0..x2   in  32  bit-reorganisation words X0, X1, X2
//   w_out    out 32  W computed from R1/R2 before update (holds when idle)
//   w_vld    out  1  one-cycle pulse per accepted triple
//   r1_o     out 32  current R1 (debug)
//   r2_o     out 32  current R2 (debug)
// ---------------------------------------------------------------------------

// ZUC S-box S0: pure table lookup.
module zuc_s0 (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] TAB = {
    8'h3e,8'h72,8'h5b,8'h47,8'hca,8'he0,8'h00,8'h33,8'h04,8'hd1,8'h54,8'h98,8'h09,8'hb9,8'h6d,8'hcb,
    8'h7b,8'h1b,8'hf9,8'h32,8'haf,8'h9d,8'h6a,8'ha5,8'hb8,8'h2d,8'hfc,8'h1d,8'h08,8'h53,8'h03,8'h90,
    8'h4d,8'h4e,8'h84,8'h99,8'he4,8'hce,8'hd9,8'h91,8'hdd,8'hb6,8'h85,8'h48,8'h8b,8'h29,8'h6e,8'hac,
    8'hcd,8'hc1,8'hf8,8'h1e,8'h73,8'h43,8'h69,8'hc6,8'hb5,8'hbd,8'hfd,8'h39,8'h63,8'h20,8'hd4,8'h38,
    8'h76,8'h7d,8'hb2,8'ha7,8'hcf,8'hed,8'h57,8'hc5,8'hf3,8'h2c,8'hbb,8'h14,8'h21,8'h06,8'h55,8'h9b,
    8'he3,8'hef,8'h5e,8'h31,8'h4f,8'h7f,8'h5a,8'ha4,8'h0d,8'h82,8'h51,8'h49,8'h5f,8'hba,8'h58,8'h1c,
    8'h4a,8'h16,8'hd5,8'h17,8'ha8,8'h92,8'h24,8'h1f,8'h8c,8'hff,8'hd8,8'hae,8'h2e,8'h01,8'hd3,8'had,
    8'h3b,8'h4b,8'hda,8'h46,8'heb,8'hc9,8'hde,8'h9a,8'h8f,8'h87,8'hd7,8'h3a,8'h80,8'h6f,8'h2f,8'hc8,
    8'hb1,8'hb4,8'h37,8'hf7,8'h0a,8'h22,8'h13,8'h28,8'h7c,8'hcc,8'h3c,8'h89,8'hc7,8'hc3,8'h96,8'h56,
    8'h07,8'hbf,8'h7e,8'hf0,8'h0b,8'h2b,8'h97,8'h52,8'h35,8'h41,8'h79,8'h61,8'ha6,8'h4c,8'h10,8'hfe,
    8'hbc,8'h26,8'h95,8'h88,8'h8a,8'hb0,8'ha3,8'hfb,8'hc0,8'h18,8'h94,8'hf2,8'he1,8'he5,8'he9,8'h5d,
    8'hd0,8'hdc,8'h11,8'h66,8'h64,8'h5c,8'hec,8'h59,8'h42,8'h75,8'h12,8'hf5,8'h74,8'h9c,8'haa,8'h23,
    8'h0e,8'h86,8'hab,8'hbe,8'h2a,8'h02,8'he7,8'h67,8'he6,8'h44,8'ha2,8'h6c,8'hc2,8'h93,8'h9f,8'hf1,
    8'hf6,8'hfa,8'h36,8'hd2,8'h50,8'h68,8'h9e,8'h62,8'h71,8'h15,8'h3d,8'hd6,8'h40,8'hc4,8'he2,8'h0f,
    8'h8e,8'h83,8'h77,8'h6b,8'h25,8'h05,8'h3f,8'h0c,8'h30,8'hea,8'h70,8'hb7,8'ha1,8'he8,8'ha9,8'h65,
    8'h8d,8'h27,8'h1a,8'hdb,8'h81,8'hb3,8'ha0,8'hf4,8'h45,8'h7a,8'h19,8'hdf,8'hee,8'h78,8'h34,8'h60
  };
  assign y_o = TAB[a_i];
endmodule

// ZUC S-box S1: pure table lookup.
module zuc_s1 (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] TAB = {
    8'h55,8'hc2,8'h63,8'h71,8'h3b,8'hc8,8'h47,8'h86,8'h9f,8'h3c,8'hda,8'h5b,8'h29,8'haa,8'hfd,8'h77,
    8'h8c,8'hc5,8'h94,8'h0c,8'ha6,8'h1a,8'h13,8'h00,8'he3,8'ha8,8'h16,8'h72,8'h40,8'hf9,8'hf8,8'h42,
    8'h44,8'h26,8'h68,8'h96,8'h81,8'hd9,8'h45,8'h3e,8'h10,8'h76,8'hc6,8'ha7,8'h8b,8'h39,8'h43,8'he1,
    8'h3a,8'hb5,8'h56,8'h2a,8'hc0,8'h6d,8'hb3,8'h05,8'h22,8'h66,8'hbf,8'hdc,8'h0b,8'hfa,8'h62,8'h48,
    8'hdd,8'h20,8'h11,8'h06,8'h36,8'hc9,8'hc1,8'hcf,8'hf6,8'h27,8'h52,8'hbb,8'h69,8'hf5,8'hd4,8'h87,
    8'h7f,8'h84,8'h4c,8'hd2,8'h9c,8'h57,8'ha4,8'hbc,8'h4f,8'h9a,8'hdf,8'hfe,8'hd6,8'h8d,8'h7a,8'heb,
    8'h2b,8'h53,8'hd8,8'h5c,8'ha1,8'h14,8'h17,8'hfb,8'h23,8'hd5,8'h7d,8'h30,8'h67,8'h73,8'h08,8'h09,
    8'hee,8'hb7,8'h70,8'h3f,8'h61,8'hb2,8'h19,8'h8e,8'h4e,8'he5,8'h4b,8'h93,8'h8f,8'h5d,8'hdb,8'ha9,
    8'had,8'hf1,8'hae,8'h2e,8'hcb,8'h0d,8'hfc,8'hf4,8'h2d,8'h46,8'h6e,8'h1d,8'h97,8'he8,8'hd1,8'he9,
    8'h4d,8'h37,8'ha5,8'h75,8'h5e,8'h83,8'h9e,8'hab,8'h82,8'h9d,8'hb9,8'h1c,8'he0,8'hcd,8'h49,8'h89,
    8'h01,8'hb6,8'hbd,8'h58,8'h24,8'ha2,8'h5f,8'h38,8'h78,8'h99,8'h15,8'h90,8'h50,8'hb8,8'h95,8'he4,
    8'hd0,8'h91,8'hc7,8'hce,8'hed,8'h0f,8'hb4,8'h6f,8'ha0,8'hcc,8'hf0,8'h02,8'h4a,8'h79,8'hc3,8'hde,
    8'ha3,8'hef,8'hea,8'h51,8'he6,8'h6b,8'h18,8'hec,8'h1b,8'h2c,8'h80,8'hf7,8'h74,8'he7,8'hff,8'h21,
    8'h5a,8'h6a,8'h54,8'h1e,8'h41,8'h31,8'h92,8'h35,8'hc4,8'h33,8'h07,8'h0a,8'hba,8'h7e,8'h0e,8'h34,
    8'h88,8'hb1,8'h98,8'h7c,8'hf3,8'h3d,8'h60,8'h6c,8'h7b,8'hca,8'hd3,8'h1f,8'h32,8'h65,8'h04,8'h28,
    8'h64,8'hbe,8'h85,8'h9b,8'h2f,8'h59,8'h8a,8'hd7,8'hb0,8'h25,8'hac,8'haf,8'h12,8'h03,8'he2,8'hf2
  };
  assign y_o = TAB[a_i];
endmodule

// 32-bit S-box layer: bytes [31:24],[15:8] through S0; [23:16],[7:0] through S1.
module zuc_sbox32 (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);
  zuc_s0 u_s0_hi (.a_i(a_i[31:24]), .y_o(y_o[31:24]));
  zuc_s1 u_s1_hi (.a_i(a_i[23:16]), .y_o(y_o[23:16]));
  zuc_s0 u_s0_lo (.a_i(a_i[15:8]),  .y_o(y_o[15:8]));
  zuc_s1 u_s1_lo (.a_i(a_i[7:0]),   .y_o(y_o[7:0]));
endmodule

module zuc_fsm #(
  parameter logic [31:0] RST_R1 = 32'h0000_0000,
  parameter logic [31:0] RST_R2 = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] w_out,
  output logic        w_vld,
  output logic [31:0] r1_o,
  output logic [31:0] r2_o
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] lin1(input logic [31:0] x);
    return x ^ rotl(x, 2) ^ rotl(x, 10) ^ rotl(x, 18) ^ rotl(x, 24);
  endfunction

  function automatic logic [31:0] lin2(input logic [31:0] x);
    return x ^ rotl(x, 8) ^ rotl(x, 14) ^ rotl(x, 22) ^ rotl(x, 30);
  endfunction

  logic [31:0] r1_q, r2_q;
  logic [31:0] w_q;
  logic        w_vld_q;

  logic [31:0] w1, w2, w_d;
  logic [31:0] l1_d, l2_d;
  logic [31:0] sb1_in, sb2_in;
  logic [31:0] r1_d, r2_d;
  logic        accept;

  // Combinational datapath; all sums wrap mod 2^32 by width truncation.
  // NOTE: always_comb assigns every output on every path, so no latches are inferred.
  always_comb begin
    w1   = r1_q + x1;
    w2   = r2_q ^ x2;
    w_d  = (x0 ^ r1_q) + r2_q;
    l1_d = lin1({w1[15:0], w2[31:16]});
    l2_d = lin2({w2[15:0], w1[31:16]});
  end

  zuc_sbox32 u_sbox_r1 (.a_i(sb1_in), .y_o(r1_d));
  zuc_sbox32 u_sbox_r2 (.a_i(sb2_in), .y_o(r2_d));

  assign accept = in_vld & in_rdy;

`ifdef ZUC_FSM_PIPE_EN

  typedef enum logic {ST_IDLE, ST_UPD} state_e;

  state_e      state_q;
  logic        in_rdy_q;
  logic [31:0] l1_q, l2_q;

  // S-boxes are fed from the L1/L2 register stage.
  assign sb1_in = l1_q;
  assign sb2_in = l2_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      in_rdy_q <= 1'b1;
      r1_q     <= RST_R1;
      r2_q     <= RST_R2;
      l1_q     <= '0;
      l2_q     <= '0;
      w_q      <= '0;
      w_vld_q  <= 1'b0;
    end else begin
      w_vld_q <= 1'b0;
      if (clr) begin
        // Abort anything in flight; the triple on the bus is dropped.
        state_q  <= ST_IDLE;
        in_rdy_q <= 1'b1;
        r1_q     <= RST_R1;
        r2_q     <= RST_R2;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              l1_q     <= l1_d;
              l2_q     <= l2_d;
              w_q      <= w_d;
              w_vld_q  <= 1'b1;
              state_q  <= ST_UPD;
              in_rdy_q <= 1'b0;
            end
          end
          ST_UPD: begin
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            state_q  <= ST_IDLE;
            in_rdy_q <= 1'b1;
          end
          default: begin
            state_q  <= ST_IDLE;
            in_rdy_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_rdy = in_rdy_q;

`else

  // S-boxes are fed straight from L1/L2; update completes on the accept edge.
  assign sb1_in = l1_d;
  assign sb2_in = l2_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q    <= RST_R1;
      r2_q    <= RST_R2;
      w_q     <= '0;
      w_vld_q <= 1'b0;
    end else if (clr) begin
      r1_q    <= RST_R1;
      r2_q    <= RST_R2;
      w_vld_q <= 1'b0;
    end else if (accept) begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      w_q     <= w_d;
      w_vld_q <= 1'b1;
    end else begin
      w_vld_q <= 1'b0;
    end
  end

  assign in_rdy = 1'b1;

`endif

  assign w_out = w_q;
  assign w_vld = w_vld_q;
  assign r1_o  = r1_q;
  assign r2_o  = r2_q;

endmodule

// File: tb/tb_zuc_fsm.sv
// ---------------------------------------------------------------------------
// tb_zuc_fsm -- self-checking bench for zuc_fsm.
// A transaction-level model of the ZUC F function (R1/R2 plus a one-deep
// "update pending" flag for the piped build) predicts W, w_vld, R1, R2 and
// in_rdy after every clock edge. Literal checks pin the zero-vector results,
// the in_rdy pattern under a held in_vld, clr and asynchronous reset.
// Build with +define+ZUC_FSM_PIPE_EN to check the piped variant.
// ---------------------------------------------------------------------------
module tb_zuc_fsm;

`ifdef ZUC_FSM_PIPE_EN
  localparam bit       PIPED   = 1'b1;
  localparam logic [5:0] RDY_PAT = 6'b101010;
  localparam int       HELD_PULSES = 3;
`else
  localparam bit       PIPED   = 1'b0;
  localparam logic [5:0] RDY_PAT = 6'b111111;
  localparam int       HELD_PULSES = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] x0, x1, x2;
  logic [31:0] w_out;
  logic        w_vld;
  logic [31:0] r1_o, r2_o;

  zuc_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .x0    (x0),
    .x1    (x1),
    .x2    (x2),
    .w_out (w_out),
    .w_vld (w_vld),
    .r1_o  (r1_o),
    .r2_o  (r2_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [0:255][7:0] s0_tab = {
    8'h3e,8'h72,8'h5b,8'h47,8'hca,8'he0,8'h00,8'h33,8'h04,8'hd1,8'h54,8'h98,8'h09,8'hb9,8'h6d,8'hcb,
    8'h7b,8'h1b,8'hf9,8'h32,8'haf,8'h9d,8'h6a,8'ha5,8'hb8,8'h2d,8'hfc,8'h1d,8'h08,8'h53,8'h03,8'h90,
    8'h4d,8'h4e,8'h84,8'h99,8'he4,8'hce,8'hd9,8'h91,8'hdd,8'hb6,8'h85,8'h48,8'h8b,8'h29,8'h6e,8'hac,
    8'hcd,8'hc1,8'hf8,8'h1e,8'h73,8'h43,8'h69,8'hc6,8'hb5,8'hbd,8'hfd,8'h39,8'h63,8'h20,8'hd4,8'h38,
    8'h76,8'h7d,8'hb2,8'ha7,8'hcf,8'hed,8'h57,8'hc5,8'hf3,8'h2c,8'hbb,8'h14,8'h21,8'h06,8'h55,8'h9b,
    8'he3,8'hef,8'h5e,8'h31,8'h4f,8'h7f,8'h5a,8'ha4,8'h0d,8'h82,8'h51,8'h49,8'h5f,8'hba,8'h58,8'h1c,
    8'h4a,8'h16,8'hd5,8'h17,8'ha8,8'h92,8'h24,8'h1f,8'h8c,8'hff,8'hd8,8'hae,8'h2e,8'h01,8'hd3,8'had,
    8'h3b,8'h4b,8'hda,8'h46,8'heb,8'hc9,8'hde,8'h9a,8'h8f,8'h87,8'hd7,8'h3a,8'h80,8'h6f,8'h2f,8'hc8,
    8'hb1,8'hb4,8'h37,8'hf7,8'h0a,8'h22,8'h13,8'h28,8'h7c,8'hcc,8'h3c,8'h89,8'hc7,8'hc3,8'h96,8'h56,
    8'h07,8'hbf,8'h7e,8'hf0,8'h0b,8'h2b,8'h97,8'h52,8'h35,8'h41,8'h79,8'h61,8'ha6,8'h4c,8'h10,8'hfe,
    8'hbc,8'h26,8'h95,8'h88,8'h8a,8'hb0,8'ha3,8'hfb,8'hc0,8'h18,8'h94,8'hf2,8'he1,8'he5,8'he9,8'h5d,
    8'hd0,8'hdc,8'h11,8'h66,8'h64,8'h5c,8'hec,8'h59,8'h42,8'h75,8'h12,8'hf5,8'h74,8'h9c,8'haa,8'h23,
    8'h0e,8'h86,8'hab,8'hbe,8'h2a,8'h02,8'he7,8'h67,8'he6,8'h44,8'ha2,8'h6c,8'hc2,8'h93,8'h9f,8'hf1,
    8'hf6,8'hfa,8'h36,8'hd2,8'h50,8'h68,8'h9e,8'h62,8'h71,8'h15,8'h3d,8'hd6,8'h40,8'hc4,8'he2,8'h0f,
    8'h8e,8'h83,8'h77,8'h6b,8'h25,8'h05,8'h3f,8'h0c,8'h30,8'hea,8'h70,8'hb7,8'ha1,8'he8,8'ha9,8'h65,
    8'h8d,8'h27,8'h1a,8'hdb,8'h81,8'hb3,8'ha0,8'hf4,8'h45,8'h7a,8'h19,8'hdf,8'hee,8'h78,8'h34,8'h60
  };

  logic [0:255][7:0] s1_tab = {
    8'h55,8'hc2,8'h63,8'h71,8'h3b,8'hc8,8'h47,8'h86,8'h9f,8'h3c,8'hda,8'h5b,8'h29,8'haa,8'hfd,8'h77,
    8'h8c,8'hc5,8'h94,8'h0c,8'ha6,8'h1a,8'h13,8'h00,8'he3,8'ha8,8'h16,8'h72,8'h40,8'hf9,8'hf8,8'h42,
    8'h44,8'h26,8'h68,8'h96,8'h81,8'hd9,8'h45,8'h3e,8'h10,8'h76,8'hc6,8'ha7,8'h8b,8'h39,8'h43,8'he1,
    8'h3a,8'hb5,8'h56,8'h2a,8'hc0,8'h6d,8'hb3,8'h05,8'h22,8'h66,8'hbf,8'hdc,8'h0b,8'hfa,8'h62,8'h48,
    8'hdd,8'h20,8'h11,8'h06,8'h36,8'hc9,8'hc1,8'hcf,8'hf6,8'h27,8'h52,8'hbb,8'h69,8'hf5,8'hd4,8'h87,
    8'h7f,8'h84,8'h4c,8'hd2,8'h9c,8'h57,8'ha4,8'hbc,8'h4f,8'h9a,8'hdf,8'hfe,8'hd6,8'h8d,8'h7a,8'heb,
    8'h2b,8'h53,8'hd8,8'h5c,8'ha1,8'h14,8'h17,8'hfb,8'h23,8'hd5,8'h7d,8'h30,8'h67,8'h73,8'h08,8'h09,
    8'hee,8'hb7,8'h70,8'h3f,8'h61,8'hb2,8'h19,8'h8e,8'h4e,8'he5,8'h4b,8'h93,8'h8f,8'h5d,8'hdb,8'ha9,
    8'had,8'hf1,8'hae,8'h2e,8'hcb,8'h0d,8'hfc,8'hf4,8'h2d,8'h46,8'h6e,8'h1d,8'h97,8'he8,8'hd1,8'he9,
    8'h4d,8'h37,8'ha5,8'h75,8'h5e,8'h83,8'h9e,8'hab,8'h82,8'h9d,8'hb9,8'h1c,8'he0,8'hcd,8'h49,8'h89,
    8'h01,8'hb6,8'hbd,8'h58,8'h24,8'ha2,8'h5f,8'h38,8'h78,8'h99,8'h15,8'h90,8'h50,8'hb8,8'h95,8'he4,
    8'hd0,8'h91,8'hc7,8'hce,8'hed,8'h0f,8'hb4,8'h6f,8'ha0,8'hcc,8'hf0,8'h02,8'h4a,8'h79,8'hc3,8'hde,
    8'ha3,8'hef,8'hea,8'h51,8'he6,8'h6b,8'h18,8'hec,8'h1b,8'h2c,8'h80,8'hf7,8'h74,8'he7,8'hff,8'h21,
    8'h5a,8'h6a,8'h54,8'h1e,8'h41,8'h31,8'h92,8'h35,8'hc4,8'h33,8'h07,8'h0a,8'hba,8'h7e,8'h0e,8'h34,
    8'h88,8'hb1,8'h98,8'h7c,8'hf3,8'h3d,8'h60,8'h6c,8'h7b,8'hca,8'hd3,8'h1f,8'h32,8'h65,8'h04,8'h28,
    8'h64,8'hbe,8'h85,8'h9b,8'h2f,8'h59,8'h8a,8'hd7,8'hb0,8'h25,8'hac,8'haf,8'h12,8'h03,8'he2,8'hf2
  };

  // ---------------- reference model ----------------
  logic [31:0] m_r1, m_r2, m_w, m_p1, m_p2;
  logic        m_wv, m_busy, m_rdy;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sbox(input logic [31:0] x);
    return {s0_tab[x[31:24]], s1_tab[x[23:16]], s0_tab[x[15:8]], s1_tab[x[7:0]]};
  endfunction

  function automatic logic [31:0] model_w(input logic [31:0] a0, input logic [31:0] r1,
                                          input logic [31:0] r2);
    return (a0 ^ r1) + r2;
  endfunction

  // Next {R1,R2} for one step of F.
  function automatic logic [63:0] f_next(input logic [31:0] r1, input logic [31:0] r2,
                                         input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] t1, t2, u, v;
    t1 = r1 + a1;
    t2 = r2 ^ a2;
    u  = {t1[15:0], t2[31:16]};
    v  = {t2[15:0], t1[31:16]};
    u  = u ^ rl(u, 2) ^ rl(u, 10) ^ rl(u, 18) ^ rl(u, 24);
    v  = v ^ rl(v, 8) ^ rl(v, 14) ^ rl(v, 22) ^ rl(v, 30);
    return {sbox(u), sbox(v)};
  endfunction

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_w = '0; m_wv = 1'b0;
    m_busy = 1'b0; m_rdy = 1'b1; m_p1 = '0; m_p2 = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [63:0] nx;
    if (clr) begin
      m_r1 = '0; m_r2 = '0; m_wv = 1'b0; m_busy = 1'b0; m_rdy = 1'b1;
    end else if (m_busy) begin
      m_r1 = m_p1; m_r2 = m_p2; m_busy = 1'b0; m_rdy = 1'b1; m_wv = 1'b0;
    end else if (in_vld && m_rdy) begin
      m_w  = model_w(x0, m_r1, m_r2);
      m_wv = 1'b1;
      nx   = f_next(m_r1, m_r2, x1, x2);
      if (PIPED) begin
        m_p1 = nx[63:32]; m_p2 = nx[31:0]; m_busy = 1'b1; m_rdy = 1'b0;
      end else begin
        m_r1 = nx[63:32]; m_r2 = nx[31:0];
      end
    end else begin
      m_wv = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check("w_vld",  {31'd0, w_vld},  {31'd0, m_wv});
    check("w_out",  w_out,           m_w);
    check("r1",     r1_o,            m_r1);
    check("r2",     r2_o,            m_r2);
    check("in_rdy", {31'd0, in_rdy}, {31'd0, m_rdy});
  endtask

  logic last_rdy;

  // Called at posedge+1: drive inputs, take one edge, compare at edge+1.
  task automatic cycle(input logic v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic cl);
    in_vld = v; x0 = a0; x1 = a1; x2 = a2; clr = cl;
    #3 last_rdy = in_rdy;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  // Asynchronous reset between edges, checked before any clock edge occurs.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_vld = 1'b0; clr = 1'b0;
    #1 model_reset();
    check("rst_w_out",  w_out,           32'h0);
    check("rst_w_vld",  {31'd0, w_vld},  32'h0);
    check("rst_in_rdy", {31'd0, in_rdy}, 32'h1);
    check("rst_r1",     r1_o,            32'h0);
    check("rst_r2",     r2_o,            32'h0);
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_vector_test();
    cycle(1'b1, '0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0);
    check("zv1_w",  w_out, 32'h0000_0000);
    check("zv1_r1", r1_o,  32'h3e55_3e55);
    check("zv1_r2", r2_o,  32'h3e55_3e55);
    cycle(1'b1, '0, '0, '0, 1'b0);
    check("zv2_wvld", {31'd0, w_vld}, 32'h1);
    check("zv2_w",    w_out,          32'h7caa_7caa);
    cycle(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [5:0] rdy_seen;
    logic [31:0] w_first[2];
    rst_n = 1'b0; clr = 1'b0; in_vld = 1'b0; x0 = '0; x1 = '0; x2 = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Zero-vector results and model pins.
    zero_vector_test();
    check("model_carry_wrap", model_w(32'h1, 32'h0, 32'hffff_ffff), 32'h0);
    check("model_zero_step",  f_next('0, '0, '0, '0), 64'h3e55_3e55_3e55_3e55 >> 32);

    // in_vld held for 6 cycles straight after reset.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, '0, '0, '0, 1'b0);
      rdy_seen[5 - i] = last_rdy;
      if (w_vld) begin
        if (pulses < 2) w_first[pulses] = w_out;
        pulses++;
      end
    end
    cycle(1'b0, '0, '0, '0, 1'b0);
    check("held_rdy_pattern", {26'd0, rdy_seen}, {26'd0, RDY_PAT});
    check("held_pulses", pulses, HELD_PULSES);
    check("held_w0", w_first[0], 32'h0000_0000);
    check("held_w1", w_first[1], 32'h7caa_7caa);

    // Mixed random traffic with occasional clr.
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom, $urandom_range(0, 99) < 3);

    // clr with a valid triple while R1/R2 are nonzero: triple dropped.
    cycle(1'b1, $urandom, $urandom, $urandom, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0);
    cycle(1'b1, $urandom, $urandom, $urandom, 1'b1);
    check("clr_r1",   r1_o,           32'h0);
    check("clr_r2",   r2_o,           32'h0);
    check("clr_wvld", {31'd0, w_vld}, 32'h0);
    check("clr_rdy",  {31'd0, in_rdy}, 32'h1);

    // 1000 back-to-back valid triples.
    for (int i = 0; i < 1000; i++)
      cycle(1'b1, $urandom, $urandom, $urandom, 1'b0);

    // Asynchronous reset right after an accept (UPD in the piped build).
    cycle(1'b1, $urandom, $urandom, $urandom, 1'b0);
    do_reset();
    zero_vector_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
